// File: rtl/buzzer_beep_sequencer_if.sv
// Beep-pattern request channel between board control (master) and the beep sequencer (slave).
interface buzzer_beep_sequencer_if #(
  parameter int unsigned MAX_MS = 3000,
  parameter int unsigned CNT_W  = 4
);
  localparam int unsigned MS_W = $clog2(MAX_MS) + 1;

  logic            req_valid_i;
  logic            req_ready_o;
  logic [CNT_W-1:0] req_count_i;
  logic [MS_W-1:0]  req_on_ms_i;
  logic [MS_W-1:0]  req_gap_ms_i;

  modport master (
    output req_valid_i, req_count_i, req_on_ms_i, req_gap_ms_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i, req_count_i, req_on_ms_i, req_gap_ms_i,
    output req_ready_o
  );
endinterface

// File: rtl/buzzer_beep_sequencer.sv
// Drives the buzzer one beep at a time over trig/period/cyc for an accepted (count, on, gap) pattern.
// Optional ack timeout on cyc is built only when BUZSEQ_ACK_TIMEOUT_EN is defined.
module buzzer_beep_sequencer #(
  parameter  int unsigned MAX_MS        = 3000,
  parameter  int unsigned CNT_W         = 4,
  parameter  int unsigned TIMEOUT_TICKS = 8,
  parameter  int unsigned SIMULATION    = 0,
  localparam int unsigned MS_W          = $clog2(MAX_MS) + 1
) (
  input  logic                  clk_i_1MHz,
  input  logic                  rst_i,
  buzzer_beep_sequencer_if.slave req,
  input  logic                  abort_i,
  output logic                  trig_o,
  output logic [MS_W-1:0]       period_ms_o,
  input  logic                  cyc_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      beeps_left_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT_DONE, S_GAP} state_t;

  state_t           state;
  logic             cyc_m, cyc_s;
  logic [9:0]       presc;
  logic             tick;
  logic [MS_W-1:0]  gap_ms_q;
  logic [MS_W-1:0]  gap_cnt;
  logic             ack_timeout;

  assign req.req_ready_o = (state == S_IDLE);
  assign busy_o          = (state != S_IDLE);
  assign tick            = (SIMULATION != 0) || (presc == 10'd999);

  always_ff @(posedge clk_i_1MHz or posedge rst_i) begin
    if (rst_i) begin
      presc <= '0;
    end else begin
      presc <= (presc == 10'd999) ? '0 : presc + 10'd1;
    end
  end

  always_ff @(posedge clk_i_1MHz or posedge rst_i) begin
    if (rst_i) begin
      cyc_m <= 1'b0;
      cyc_s <= 1'b0;
    end else begin
      cyc_m <= cyc_i;
      cyc_s <= cyc_m;
    end
  end

`ifdef BUZSEQ_ACK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);
  logic [TO_W-1:0] to_cnt;

  assign ack_timeout = (state == S_TRIG) && !cyc_s && tick &&
                       (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

  // Restarts on every entry into TRIG because it is held at 0 in all other states.
  always_ff @(posedge clk_i_1MHz or posedge rst_i) begin
    if (rst_i) begin
      to_cnt <= '0;
    end else if (state != S_TRIG) begin
      to_cnt <= '0;
    end else if (tick && to_cnt != TO_W'(TIMEOUT_TICKS - 1)) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i_1MHz or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (state == S_IDLE && req.req_valid_i) begin
      err_o <= 1'b0;
    end else if (ack_timeout && !abort_i) begin
      err_o <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_TICKS == 0);
  assign ack_timeout        = 1'b0;
  assign err_o              = 1'b0;
`endif

  always_ff @(posedge clk_i_1MHz or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      trig_o       <= 1'b0;
      period_ms_o  <= '0;
      done_o       <= 1'b0;
      beeps_left_o <= '0;
      gap_ms_q     <= '0;
      gap_cnt      <= '0;
    end else begin
      done_o <= 1'b0;
      if (state != S_IDLE && abort_i) begin
        state        <= S_IDLE;
        trig_o       <= 1'b0;
        beeps_left_o <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (req.req_valid_i) begin
              period_ms_o  <= req.req_on_ms_i;
              beeps_left_o <= req.req_count_i;
              gap_ms_q     <= req.req_gap_ms_i;
              if (req.req_count_i == '0) begin
                done_o <= 1'b1;
              end else begin
                state  <= S_TRIG;
                trig_o <= 1'b1;
              end
            end
          end
          S_TRIG: begin
            if (cyc_s) begin
              state  <= S_WAIT_DONE;
              trig_o <= 1'b0;
            end else if (ack_timeout) begin
              state  <= S_IDLE;
              trig_o <= 1'b0;
            end
          end
          S_WAIT_DONE: begin
            if (!cyc_s) begin
              if (beeps_left_o != '0) beeps_left_o <= beeps_left_o - CNT_W'(1);
              if (beeps_left_o <= CNT_W'(1)) begin
                state  <= S_IDLE;
                done_o <= 1'b1;
              end else if (gap_ms_q == '0) begin
                state  <= S_TRIG;
                trig_o <= 1'b1;
              end else begin
                gap_cnt <= gap_ms_q;
                state   <= S_GAP;
              end
            end
          end
          S_GAP: begin
            if (gap_cnt == '0) begin
              state  <= S_TRIG;
              trig_o <= 1'b1;
            end else if (tick) begin
              gap_cnt <= gap_cnt - MS_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_beep_sequencer.sv
// Directed bench for buzzer_beep_sequencer with a behavioural buzzer and a trig/done scoreboard.
module tb_buzzer_beep_sequencer;
  localparam int unsigned MAX_MS = 3000;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MS_W   = $clog2(MAX_MS) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             abort;
  logic             trig;
  logic             cyc = 1'b0;
  logic             busy;
  logic             done;
  logic             err;
  logic [MS_W-1:0]  period;
  logic [CNT_W-1:0] bleft;

  buzzer_beep_sequencer_if #(.MAX_MS(MAX_MS), .CNT_W(CNT_W)) req_if ();

  buzzer_beep_sequencer #(
    .MAX_MS(MAX_MS), .CNT_W(CNT_W), .TIMEOUT_TICKS(8), .SIMULATION(1)
  ) dut (
    .clk_i_1MHz  (clk),
    .rst_i       (rst),
    .req         (req_if),
    .abort_i     (abort),
    .trig_o      (trig),
    .period_ms_o (period),
    .cyc_i       (cyc),
    .busy_o      (busy),
    .done_o      (done),
    .beeps_left_o(bleft),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  always @(posedge clk) cycle++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Buzzer model: cyc rises 2 clk after trig rises and stays high period_ms clk.
  logic model_en = 1'b1;
  logic trig_q   = 1'b0;
  int   dly = 0, len = 0;
  always @(posedge clk) begin
    if (rst) begin
      cyc <= 1'b0; dly <= 0; len <= 0; trig_q <= 1'b0;
    end else begin
      trig_q <= trig;
      if (dly > 0) begin
        dly <= dly - 1;
        if (dly == 1) begin cyc <= 1'b1; len <= int'(period); end
      end else if (len > 0) begin
        len <= len - 1;
        if (len == 1) cyc <= 1'b0;
      end
      if (model_en && trig && !trig_q) dly <= 1;
    end
  end

  typedef struct {
    logic [CNT_W-1:0] bl;
    logic [MS_W-1:0]  per;
    int               gap_clk;
  } beep_t;
  beep_t exp_beeps[$];
  int    exp_done[$];

  logic trig_prev = 1'b0;
  int   last_rise = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (trig && !trig_prev) begin
        chk("trig_expected", 32'(exp_beeps.size() != 0), 32'd1);
        if (exp_beeps.size() != 0) begin
          beep_t e;
          e = exp_beeps.pop_front();
          chk("beeps_left_at_trig", 32'(bleft), 32'(e.bl));
          chk("period_at_trig", 32'(period), 32'(e.per));
          if (e.gap_clk > 0) chk("trig_spacing", 32'(cycle - last_rise), 32'(e.gap_clk));
        end
        last_rise = cycle;
      end
      trig_prev = trig;
      if (done) begin
        chk("done_expected", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) void'(exp_done.pop_front());
      end
    end
  end

  task automatic push_exp(input int cnt, input int on, input int gap, input int ntrig, input bit dn);
    for (int k = 0; k < ntrig; k++) begin
      beep_t e;
      e.bl      = CNT_W'(cnt - k);
      e.per     = MS_W'(on);
      e.gap_clk = (k == 0) ? 0 : on + 5 + ((gap == 0) ? 0 : gap + 1);
      exp_beeps.push_back(e);
    end
    if (dn) exp_done.push_back(1);
  endtask

  task automatic drive_req(input int cnt, input int on, input int gap);
    @(negedge clk);
    req_if.req_valid_i  = 1'b1;
    req_if.req_count_i  = CNT_W'(cnt);
    req_if.req_on_ms_i  = MS_W'(on);
    req_if.req_gap_ms_i = MS_W'(gap);
    @(negedge clk);
    req_if.req_valid_i  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin @(negedge clk); n++; end
    chk(tag, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_sb_empty(input string tag);
    chk({tag, "_trigs_left"}, 32'(exp_beeps.size()), 32'd0);
    chk({tag, "_dones_left"}, 32'(exp_done.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; abort = 1'b0;
    req_if.req_valid_i = 1'b0; req_if.req_count_i = '0;
    req_if.req_on_ms_i = '0;   req_if.req_gap_ms_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_if.req_ready_o), 32'd1);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_beeps_left", 32'(bleft), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 3 beeps, on 5, gap 4
    push_exp(3, 5, 4, 3, 1'b1);
    drive_req(3, 5, 4);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(req_if.req_ready_o), 32'd0);
    chk("t1_beeps_left", 32'(bleft), 32'd3);
    wait_idle("t1_idle", 200);
    chk_sb_empty("t1");
    chk("t1_final_beeps_left", 32'(bleft), 32'd0);
    chk("t1_period_held", 32'(period), 32'd5);

    // zero-count request
    push_exp(0, 7, 2, 0, 1'b1);
    drive_req(0, 7, 2);
    chk("t2_done_pulse", 32'(done), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_period", 32'(period), 32'd7);
    @(negedge clk);
    chk("t2_done_single", 32'(done), 32'd0);
    chk("t2_no_trig", 32'(trig), 32'd0);
    chk_sb_empty("t2");

    // back-to-back beeps with zero gap
    push_exp(2, 4, 0, 2, 1'b1);
    drive_req(2, 4, 0);
    wait_idle("t3_idle", 200);
    chk_sb_empty("t3");

    // abort during the second gap of a 4-beep pattern
    push_exp(4, 3, 6, 2, 1'b0);
    drive_req(4, 3, 6);
    n = 0;
    while (exp_beeps.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("t4_second_trig_seen", 32'(exp_beeps.size()), 32'd0);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_beeps_left", 32'(bleft), 32'd0);
    chk("t4_trig", 32'(trig), 32'd0);
    chk("t4_ready", 32'(req_if.req_ready_o), 32'd1);
    chk("t4_done", 32'(done), 32'd0);
    repeat (40) @(negedge clk);
    chk_sb_empty("t4");

    // request held while busy is ignored; next one accepted right after done
    push_exp(1, 3, 0, 1, 1'b1);
    push_exp(2, 4, 2, 2, 1'b1);
    @(negedge clk);
    req_if.req_valid_i  = 1'b1;
    req_if.req_count_i  = CNT_W'(1);
    req_if.req_on_ms_i  = MS_W'(3);
    req_if.req_gap_ms_i = MS_W'(0);
    @(negedge clk);
    req_if.req_count_i  = CNT_W'(2);
    req_if.req_on_ms_i  = MS_W'(4);
    req_if.req_gap_ms_i = MS_W'(2);
    chk("t5_first_beeps_left", 32'(bleft), 32'd1);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    chk("t5_done_seen", 32'(done), 32'd1);
    chk("t5_idle_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    req_if.req_valid_i = 1'b0;
    chk("t5_accept_after_done", 32'(busy), 32'd1);
    chk("t5_second_beeps_left", 32'(bleft), 32'd2);
    chk("t5_second_period", 32'(period), 32'd4);
    wait_idle("t5_idle", 200);
    chk_sb_empty("t5");

`ifdef BUZSEQ_ACK_TIMEOUT_EN
    // buzzer never acknowledges
    model_en = 1'b0;
    push_exp(1, 5, 0, 1, 1'b0);
    drive_req(1, 5, 0);
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    chk("t6_timeout_ticks", 32'(n), 32'd8);
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_trig", 32'(trig), 32'd0);
    repeat (5) @(negedge clk);
    chk("t6_err_sticky", 32'(err), 32'd1);
    chk_sb_empty("t6");
    model_en = 1'b1;
    push_exp(0, 5, 0, 0, 1'b1);
    drive_req(0, 5, 0);
    chk("t6_err_cleared", 32'(err), 32'd0);
    @(negedge clk);
    chk_sb_empty("t6b");
`else
    chk("err_tied_low", 32'(err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
